// File: rtl/fft_stream_param.sv
// Streaming radix-2 DIT FFT/IFFT: load N samples, compute in place, unload bins.
// Ports: clk, rst (async low), ifft mode, in_* load handshake, out_* bin stream, busy, ovf.
module fft_stream_param #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ifft,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [W-1:0]         in_re,
  input  logic signed [W-1:0]         in_im,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [W-1:0]         out_re,
  output logic signed [W-1:0]         out_im,
  output logic [$clog2(N)-1:0]        out_idx,
  output logic                        out_last,
  output logic                        busy,
  output logic                        ovf
);

  localparam int L  = $clog2(N);
  localparam int H  = N / 2;
  localparam int SW = $clog2(L);
  localparam int P  = 2 * W;
  localparam int Q  = 2 * W + 2;
  localparam int E  = W + 2;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_UNLOAD = 2'd2;

  localparam real PI = 3.14159265358979323846;
  localparam real QS = 2.0 ** (W - 2);

  localparam logic signed [E-1:0] MAXV = E'((1 << (W - 1)) - 1);
  localparam logic signed [E-1:0] MINV = E'(-(1 << (W - 1)));

  function automatic int tw_round(input real x);
    if (x >= 0.0)
      return $rtoi(x + 0.5);
    else
      return -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++)
      r[i] = v[L-1-i];
    return r;
  endfunction

  // Bit W flags that clamping was needed.
  function automatic logic [W:0] sat(input logic signed [E-1:0] v);
    if (v > MAXV)
      return {1'b1, MAXV[W-1:0]};
    else if (v < MINV)
      return {1'b1, MINV[W-1:0]};
    else
      return {1'b0, v[W-1:0]};
  endfunction

  logic [1:0]   state;
  logic [L-1:0] ld_cnt;
  logic [SW-1:0] stg;
  logic [L-2:0] bf;
  logic         mode;

  logic signed [W-1:0] mem_re [N];
  logic signed [W-1:0] mem_im [N];

  // Twiddle magnitudes; sign of the sine term follows the frame mode.
  logic signed [W-1:0] cos_t [H];
  logic signed [W-1:0] sin_t [H];

  for (genvar k = 0; k < H; k++) begin : g_tw
    assign cos_t[k] = W'(tw_round(QS * $cos(2.0 * PI * k / N)));
    assign sin_t[k] = W'(tw_round(QS * $sin(2.0 * PI * k / N)));
  end

  logic         accept;
  logic [L-1:0] bfx;
  logic [L-1:0] half;
  logic [L-1:0] pos;
  logic [L-1:0] a_ad;
  logic [L-1:0] b_ad;
  logic [L-2:0] k_ad;
  logic [L-1:0] nx_idx;

  assign in_ready = rst & (state == S_LOAD);
  assign busy     = (state == S_CALC) | (state == S_UNLOAD);
  assign accept   = in_valid & in_ready;
  assign nx_idx   = out_idx + 1'b1;

  // Butterfly bf of stage stg: groups of 2*half, pos inside a group.
  assign bfx  = {1'b0, bf};
  assign half = L'(1) << stg;
  assign pos  = bfx & (half - 1'b1);
  assign a_ad = (((bfx >> stg) << stg) << 1) + pos;
  assign b_ad = a_ad + half;
  assign k_ad = (L-1)'(pos << (SW'(L - 1) - stg));

  logic signed [W-1:0] ar, ai, br, bi, tr, ti;
  logic signed [P-1:0] m0, m1, m2, m3;
  logic signed [Q-1:0] pr, pi;
  logic signed [E-1:0] tre, tim;
  logic signed [E-1:0] s_re, s_im, d_re, d_im;
  logic [W:0]          ya_re, ya_im, yb_re, yb_im;
  logic                sat_any;

  assign ar = mem_re[a_ad];
  assign ai = mem_im[a_ad];
  assign br = mem_re[b_ad];
  assign bi = mem_im[b_ad];
  assign tr = cos_t[k_ad];
  assign ti = mode ? sin_t[k_ad] : -sin_t[k_ad];

  assign m0 = P'(br) * P'(tr);
  assign m1 = P'(bi) * P'(ti);
  assign m2 = P'(br) * P'(ti);
  assign m3 = P'(bi) * P'(tr);
  assign pr = Q'(m0) - Q'(m1);
  assign pi = Q'(m2) + Q'(m3);

  // Product scaled back by the twiddle weight; floor rounding.
  assign tre = E'(pr >>> (W - 2));
  assign tim = E'(pi >>> (W - 2));

  // Each stage halves, giving 1/N overall.
  assign s_re = (E'(ar) + tre) >>> 1;
  assign s_im = (E'(ai) + tim) >>> 1;
  assign d_re = (E'(ar) - tre) >>> 1;
  assign d_im = (E'(ai) - tim) >>> 1;

  assign ya_re = sat(s_re);
  assign ya_im = sat(s_im);
  assign yb_re = sat(d_re);
  assign yb_im = sat(d_im);
  assign sat_any = ya_re[W] | ya_im[W] | yb_re[W] | yb_im[W];

  // Sample storage is not reset; outputs only read it in UNLOAD.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      if (accept) begin
        mem_re[bitrev(ld_cnt)] <= in_re;
        mem_im[bitrev(ld_cnt)] <= in_im;
      end
    end else if (state == S_CALC) begin
      mem_re[a_ad] <= ya_re[W-1:0];
      mem_im[a_ad] <= ya_im[W-1:0];
      mem_re[b_ad] <= yb_re[W-1:0];
      mem_im[b_ad] <= yb_im[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_LOAD;
      ld_cnt    <= '0;
      stg       <= '0;
      bf        <= '0;
      mode      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            if (ld_cnt == '0)
              mode <= ifft;
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == L'(N - 1)) begin
              state <= S_CALC;
              stg   <= '0;
              bf    <= '0;
            end
          end
        end
        S_CALC: begin
          if (sat_any)
            ovf <= 1'b1;
          bf <= bf + 1'b1;
          if (bf == '1) begin
            stg <= stg + 1'b1;
            if (stg == SW'(L - 1))
              state <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          // First UNLOAD cycle primes the output register with bin 0.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_re    <= mem_re[0];
            out_im    <= mem_im[0];
          end else if (out_ready) begin
            if (out_last) begin
              state     <= S_LOAD;
              out_valid <= 1'b0;
              out_idx   <= '0;
              out_last  <= 1'b0;
              out_re    <= '0;
              out_im    <= '0;
              ovf       <= 1'b0;
            end else begin
              out_idx  <= nx_idx;
              out_last <= (out_idx == L'(N - 2));
              out_re   <= mem_re[nx_idx];
              out_im   <= mem_im[nx_idx];
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stream_param.sv
// Testbench for fft_stream_param: randomized frames vs an array-based FFT model.
// Drives/samples on the falling edge; prints one summary line.
module tb_fft_stream_param;

  localparam int N = 64;
  localparam int W = 16;
  localparam int L = 6;
  localparam int C = (N / 2) * L;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ifft = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic in_ready, out_valid, out_last, busy, ovf;
  logic signed [W-1:0] out_re, out_im;
  logic [L-1:0] out_idx;

  int tests = 0;
  int fails = 0;
  int twr [N/2];
  int tws [N/2];
  int in_r [N];
  int in_i [N];
  int exp_r [N];
  int exp_i [N];
  int got_r [N];
  int got_i [N];
  bit exp_ovf;
  bit got_ovf;

  always #5 clk = ~clk;

  fft_stream_param #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .ifft(ifft),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .ovf(ovf)
  );

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int brev(input int n);
    int r = 0;
    for (int i = 0; i < L; i++)
      if ((n >> i) & 1) r |= 1 << (L - 1 - i);
    return r;
  endfunction

  function automatic longint satv(input longint v);
    if (v > 32767) begin exp_ovf = 1; return 32767; end
    if (v < -32768) begin exp_ovf = 1; return -32768; end
    return v;
  endfunction

  // Textbook in-place DIT: bit-reverse, then log2(N) halving stages.
  task automatic run_model(input bit inv);
    longint xr [N];
    longint xi [N];
    longint tr, ti, pr, pi, ur, ui;
    int h, st, p, q, k;
    for (int n = 0; n < N; n++) begin
      xr[brev(n)] = in_r[n];
      xi[brev(n)] = in_i[n];
    end
    exp_ovf = 0;
    for (int len = 2; len <= N; len = len * 2) begin
      h = len / 2;
      st = N / len;
      for (int s0 = 0; s0 < N; s0 += len) begin
        for (int j = 0; j < h; j++) begin
          k = j * st;
          p = s0 + j;
          q = p + h;
          tr = twr[k];
          ti = inv ? tws[k] : -tws[k];
          pr = (xr[q] * tr - xi[q] * ti) >>> (W - 2);
          pi = (xr[q] * ti + xi[q] * tr) >>> (W - 2);
          ur = xr[p];
          ui = xi[p];
          xr[p] = satv((ur + pr) >>> 1);
          xi[p] = satv((ui + pi) >>> 1);
          xr[q] = satv((ur - pr) >>> 1);
          xi[q] = satv((ui - pi) >>> 1);
        end
      end
    end
    for (int n = 0; n < N; n++) begin
      exp_r[n] = int'(xr[n]);
      exp_i[n] = int'(xi[n]);
    end
  endtask

  task automatic send_frame(input bit inv, input bit gaps,
                            input bit toggle, input int nb);
    int n = 0;
    int guard = 0;
    ifft = inv;
    while (n < nb && guard < 40 * N) begin
      @(negedge clk);
      guard++;
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_re = W'(in_r[n]);
      in_im = W'(in_i[n]);
      if (toggle && n > 0) ifft = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) n++;
    end
    tests++;
    if (n != nb) begin
      fails++;
      $display("FAIL send_timeout: accepted %0d, required %0d", n, nb);
    end
  endtask

  task automatic recv_frame(input bit rand_rdy, input bit chk_lat);
    int lat = 0;
    int idx = 0;
    int guard = 0;
    bit calc_ok = 1;
    out_ready = 1'b0;
    while (!out_valid && lat < 4 * C) begin
      @(negedge clk);
      lat++;
      if (!out_valid && (!busy || in_ready)) calc_ok = 0;
      in_valid = 1'($urandom_range(0, 1));
      in_re = W'($urandom);
      in_im = W'($urandom);
      ifft = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    tests++;
    if (!calc_ok) begin
      fails++;
      $display("FAIL calc_busy: busy/in_ready wrong while computing");
    end
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL out_timeout: no out_valid after %0d cycles", lat);
      return;
    end
    if (chk_lat) begin
      tests++;
      if (lat - 1 != C + 1) begin
        fails++;
        $display("FAIL latency: got %0d, required %0d", lat - 1, C + 1);
      end
    end
    while (idx < N && guard < 40 * N) begin
      tests++;
      if (!out_valid) begin
        fails++;
        $display("FAIL valid_drop: at bin %0d", idx);
        out_ready = 1'b0;
      end else begin
        tests++;
        if (int'(out_idx) != idx) begin
          fails++;
          $display("FAIL out_idx: got %0d, required %0d", out_idx, idx);
        end
        tests++;
        if (out_last != (idx == N - 1)) begin
          fails++;
          $display("FAIL out_last: bin %0d got %0b", idx, out_last);
        end
        tests++;
        if (int'(out_re) != exp_r[idx] || int'(out_im) != exp_i[idx]) begin
          fails++;
          $display("FAIL bin_value: bin %0d got (%0d,%0d), required (%0d,%0d)",
                   idx, out_re, out_im, exp_r[idx], exp_i[idx]);
        end
        tests++;
        if (ovf != exp_ovf) begin
          fails++;
          $display("FAIL ovf_flag: bin %0d got %0b, required %0b", idx, ovf, exp_ovf);
        end
        got_r[idx] = int'(out_re);
        got_i[idx] = int'(out_im);
        got_ovf = ovf;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) idx++;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    tests++;
    if (idx != N) begin
      fails++;
      $display("FAIL recv_timeout: got %0d bins, required %0d", idx, N);
    end
    tests++;
    if (!in_ready || out_valid || busy || ovf) begin
      fails++;
      $display("FAIL return_load: in_ready=%0b out_valid=%0b busy=%0b ovf=%0b, required 1 0 0 0",
               in_ready, out_valid, busy, ovf);
    end
  endtask

  task automatic check_dc();
    int bad = 0;
    for (int n = 1; n < N; n++)
      if (got_r[n] != 0 || got_i[n] != 0) bad++;
    tests++;
    if (got_r[0] != 1024 || got_i[0] != 0) begin
      fails++;
      $display("FAIL dc_bin0: got (%0d,%0d), required (1024,0)", got_r[0], got_i[0]);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL dc_other_bins: %0d nonzero, required 0", bad);
    end
    tests++;
    if (got_ovf != 1'b0) begin
      fails++;
      $display("FAIL dc_ovf: got %0b, required 0", got_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready || out_valid || busy || ovf || out_last ||
        out_idx != '0 || out_re != '0 || out_im != '0) begin
      fails++;
      $display("FAIL reset_state: rdy=%0b v=%0b busy=%0b ovf=%0b last=%0b idx=%0d re=%0d im=%0d",
               in_ready, out_valid, busy, ovf, out_last, out_idx, out_re, out_im);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (!in_ready || busy) begin
      fails++;
      $display("FAIL reset_release: in_ready=%0b busy=%0b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_dc();
    for (int n = 0; n < N; n++) begin in_r[n] = 1024; in_i[n] = 0; end
    run_model(0);
    send_frame(0, 0, 0, N);
    recv_frame(0, 1);
    check_dc();
  endtask

  task automatic test_half_ones();
    int bad = 0;
    for (int n = 0; n < N; n++) begin in_r[n] = (n < 32) ? 32 : 0; in_i[n] = 0; end
    run_model(0);
    send_frame(0, 0, 0, N);
    recv_frame(0, 1);
    for (int n = 2; n < N; n += 2)
      if (got_r[n] != 0 || got_i[n] != 0) bad++;
    tests++;
    if (got_r[0] != 16 || got_i[0] != 0) begin
      fails++;
      $display("FAIL half_bin0: got (%0d,%0d), required (16,0)", got_r[0], got_i[0]);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL half_even_bins: %0d nonzero, required 0", bad);
    end
  endtask

  task automatic test_ifft_impulse();
    int bad = 0;
    for (int n = 0; n < N; n++) begin in_r[n] = (n == 0) ? 1024 : 0; in_i[n] = 0; end
    run_model(1);
    send_frame(1, 1, 0, N);
    recv_frame(0, 1);
    for (int n = 0; n < N; n++)
      if (got_r[n] != 16 || got_i[n] != 0) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL ifft_flat: %0d bins differ from (16,0)", bad);
    end
  endtask

  task automatic test_alternating();
    for (int n = 0; n < N; n++) begin
      in_r[n] = (n % 2 == 0) ? 32767 : -32768;
      in_i[n] = 0;
    end
    run_model(0);
    send_frame(0, 0, 0, N);
    recv_frame(0, 1);
    tests++;
    if (got_ovf != 1'b0) begin
      fails++;
      $display("FAIL alt_ovf: got %0b, required 0", got_ovf);
    end
    tests++;
    if (got_r[32] != 32767) begin
      fails++;
      $display("FAIL alt_bin32: got %0d, required 32767", got_r[32]);
    end
    tests++;
    if (got_r[0] < -1 || got_r[0] > 1) begin
      fails++;
      $display("FAIL alt_bin0: got %0d, required within 1 of 0", got_r[0]);
    end
  endtask

  task automatic test_backpressure();
    bit inv;
    for (int f = 0; f < 4; f++) begin
      inv = 1'($urandom_range(0, 1));
      for (int n = 0; n < N; n++) begin
        in_r[n] = int'($urandom_range(0, 8000)) - 4000;
        in_i[n] = int'($urandom_range(0, 8000)) - 4000;
      end
      run_model(inv);
      send_frame(inv, 1, (f == 2), N);
      recv_frame(1, 0);
    end
  endtask

  task automatic test_back_to_back();
    bit inv;
    for (int f = 0; f < 2; f++) begin
      inv = 1'(f);
      for (int n = 0; n < N; n++) begin
        in_r[n] = int'($urandom_range(0, 65535)) - 32768;
        in_i[n] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_model(inv);
      send_frame(inv, 0, 0, N);
      recv_frame(1, 1);
    end
  endtask

  task automatic test_reset_midframe();
    for (int n = 0; n < N; n++) begin
      in_r[n] = int'($urandom_range(0, 2000)) - 1000;
      in_i[n] = int'($urandom_range(0, 2000)) - 1000;
    end
    send_frame(0, 1, 0, 40);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    tests++;
    if (busy || in_ready || out_valid) begin
      fails++;
      $display("FAIL midreset_state: busy=%0b in_ready=%0b out_valid=%0b", busy, in_ready, out_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (!in_ready || busy) begin
      fails++;
      $display("FAIL midreset_reload: in_ready=%0b busy=%0b", in_ready, busy);
    end
    send_frame(1, 0, 0, N);
    repeat (50) @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    tests++;
    if (busy || out_valid || ovf) begin
      fails++;
      $display("FAIL calcreset_state: busy=%0b out_valid=%0b ovf=%0b", busy, out_valid, ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_dc();
  endtask

  initial begin
    for (int k = 0; k < N / 2; k++) begin
      twr[k] = rnd(16384.0 * $cos(2.0 * PI * k / N));
      tws[k] = rnd(16384.0 * $sin(2.0 * PI * k / N));
    end
    test_reset();
    test_dc();
    test_half_ones();
    test_ifft_impulse();
    test_alternating();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
